mem_stage: RTL and testbench

- Memory-access stage directly upstream of the MEM/WB pipeline register.
- Consumes EX/MEM outputs and performs loads/stores against an internal 64-bit word data memory with a fixed multi-cycle latency.
- Stalls upstream while an access is in flight, then presents MEM_WRegEn / MEM_Dout / MEM_WReg1 for one cycle to MEM/WB.
- Non-memory instructions pass through with 1-cycle latency.

---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/dmem_array.sv | 28 ++
 rtl/mem_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// MEM_STAGE_RANGE_CHECK_EN enables the address check in mem_stage. The check uses addr_bad().
package mem_stage_pkg;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned DEF_LAT   = 2;

  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } state_e;

  // An address is bad when it is misaligned (low 3 bits set).
  // It is also bad when it is out of range (bits above the word index set).
  function automatic logic addr_bad(input logic [WORD_W-1:0] addr, input int unsigned addr_w);
    return (addr[2:0] != 3'b000) || ((addr >> (addr_w + 3)) != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data memory.
// It has one synchronous write port and one combinational read port. Contents are never reset.
module dmem_array
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Write port: commits on the rising edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage feeding the MEM/WB register.
// Loads and stores stall upstream for LAT cycles. Other instructions pass through in one cycle.
// Optional: define MEM_STAGE_RANGE_CHECK_EN to flag misaligned or out-of-range memory addresses
// on MEM_Err. Without it, MEM_Err is constant 0.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LAT    = DEF_LAT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 EX_Valid,
  input  logic                 EX_MemRead,
  input  logic                 EX_MemWrite,
  input  logic                 EX_WRegEn,
  input  logic [REG_IDX_W-1:0] EX_WReg1,
  input  logic [WORD_W-1:0]    EX_ALUout,
  input  logic [WORD_W-1:0]    EX_StoreData,
  output logic                 MEM_Stall,
  output logic                 MEM_WRegEn,
  output logic [WORD_W-1:0]    MEM_Dout,
  output logic [REG_IDX_W-1:0] MEM_WReg1,
  output logic                 MEM_Err
);

  localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Operation latched at accept time.
  logic                 store_q, store_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]    data_q, data_d;
  logic                 wen_q, wen_d;
  logic [REG_IDX_W-1:0] wreg_q, wreg_d;
  logic                 bad_q, bad_d;

  // Registered stage outputs.
  logic                 out_wen_q, out_wen_d;
  logic [WORD_W-1:0]    out_dout_q, out_dout_d;
  logic [REG_IDX_W-1:0] out_wreg_q, out_wreg_d;
  logic                 out_err_q, out_err_d;

  logic                 mem_op;
  logic                 addr_err;
  logic                 mem_we;
  logic [WORD_W-1:0]    rdata;

  assign mem_op = EX_MemRead | EX_MemWrite;

`ifdef MEM_STAGE_RANGE_CHECK_EN
  assign addr_err = addr_bad(EX_ALUout, ADDR_W);
`else
  // Without the check, the offset and high address bits are simply dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{EX_ALUout[2:0], EX_ALUout[WORD_W-1:ADDR_W+3]};
  assign addr_err = 1'b0;
`endif

  // Next-state, latch and output logic; every target defaults to hold or bubble.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    store_d    = store_q;
    idx_d      = idx_q;
    data_d     = data_q;
    wen_d      = wen_q;
    wreg_d     = wreg_q;
    bad_d      = bad_q;
    out_wen_d  = 1'b0;
    out_dout_d = '0;
    out_wreg_d = '0;
    out_err_d  = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (EX_Valid) begin
          if (mem_op) begin
            // MemRead together with MemWrite is treated as a store.
            store_d = EX_MemWrite;
            idx_d   = EX_ALUout[ADDR_W+2:3];
            data_d  = EX_StoreData;
            wen_d   = EX_WRegEn;
            wreg_d  = EX_WReg1;
            bad_d   = addr_err;
            cnt_d   = CNT_W'(LAT - 1);
            state_d = BUSY;
          end else begin
            out_wen_d  = EX_WRegEn;
            out_dout_d = EX_ALUout;
            out_wreg_d = EX_WReg1;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          if (bad_q) begin
            out_err_d = 1'b1;
          end else if (store_q) begin
            mem_we = 1'b1;
          end else begin
            out_wen_d  = wen_q;
            out_dout_d = rdata;
            out_wreg_d = wreg_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched operation and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      store_q    <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      wen_q      <= 1'b0;
      wreg_q     <= '0;
      bad_q      <= 1'b0;
      out_wen_q  <= 1'b0;
      out_dout_q <= '0;
      out_wreg_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      store_q    <= store_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      wen_q      <= wen_d;
      wreg_q     <= wreg_d;
      bad_q      <= bad_d;
      out_wen_q  <= out_wen_d;
      out_dout_q <= out_dout_d;
      out_wreg_q <= out_wreg_d;
      out_err_q  <= out_err_d;
    end
  end

  // Reset suppresses a store that would otherwise commit on the same edge.
  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk_i   (clk),
    .we_i    (mem_we & ~reset),
    .waddr_i (idx_q),
    .wdata_i (data_q),
    .raddr_i (idx_q),
    .rdata_o (rdata)
  );

  assign MEM_Stall  = (state_q == BUSY);
  assign MEM_WRegEn = out_wen_q;
  assign MEM_Dout   = out_dout_q;
  assign MEM_WReg1  = out_wreg_q;
`ifdef MEM_STAGE_RANGE_CHECK_EN
  assign MEM_Err    = out_err_q;
`else
  assign MEM_Err    = 1'b0;
  logic unused_err;
  assign unused_err = out_err_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with default parameters (LAT=2).
module tb_mem_stage;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_memread, ex_memwrite, ex_wregen;
  logic [4:0]  ex_wreg1;
  logic [63:0] ex_aluout, ex_storedata;
  logic        mem_stall, mem_wregen, mem_err;
  logic [63:0] mem_dout;
  logic [4:0]  mem_wreg1;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage dut (
    .clk          (clk),
    .reset        (reset),
    .EX_Valid     (ex_valid),
    .EX_MemRead   (ex_memread),
    .EX_MemWrite  (ex_memwrite),
    .EX_WRegEn    (ex_wregen),
    .EX_WReg1     (ex_wreg1),
    .EX_ALUout    (ex_aluout),
    .EX_StoreData (ex_storedata),
    .MEM_Stall    (mem_stall),
    .MEM_WRegEn   (mem_wregen),
    .MEM_Dout     (mem_dout),
    .MEM_WReg1    (mem_wreg1),
    .MEM_Err      (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs are stable there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_valid    = 1'b0;
    ex_memread  = 1'b0;
    ex_memwrite = 1'b0;
    ex_wregen   = 1'b0;
    ex_wreg1    = '0;
    ex_aluout   = '0;
    ex_storedata = '0;
  endtask

  task automatic check_out(input string tag, input logic wen, input logic [4:0] wreg,
                           input logic [63:0] dout, input logic err);
    check({tag, ".wen"},  {63'd0, mem_wregen}, {63'd0, wen});
    check({tag, ".wreg"}, {59'd0, mem_wreg1},  {59'd0, wreg});
    check({tag, ".dout"}, mem_dout, dout);
    check({tag, ".err"},  {63'd0, mem_err},    {63'd0, err});
  endtask

  // Issue one memory op. The bench scribbles on EX_* while the stall is high.
  // It returns in the result cycle T+LAT+1 with the inputs idle.
  task automatic mem_op(input string tag, input logic rd, input logic wr, input logic wen,
                        input logic [4:0] wreg, input logic [63:0] addr, input logic [63:0] data);
    ex_valid = 1'b1; ex_memread = rd; ex_memwrite = wr; ex_wregen = wen;
    ex_wreg1 = wreg; ex_aluout = addr; ex_storedata = data;
    step();
    for (int i = 0; i < LAT; i++) begin
      check({tag, ".stall"}, {63'd0, mem_stall}, 64'd1);
      check({tag, ".busy_wen"}, {63'd0, mem_wregen}, 64'd0);
      ex_valid = 1'b1; ex_memread = ~rd; ex_memwrite = ~wr; ex_wregen = ~wen;
      ex_wreg1 = ~wreg; ex_aluout = ~addr; ex_storedata = ~data;
      step();
    end
    idle_in();
    check({tag, ".unstall"}, {63'd0, mem_stall}, 64'd0);
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_out("reset", 1'b0, 5'd0, 64'd0, 1'b0);
    check("reset.stall", {63'd0, mem_stall}, 64'd0);

    // ALU pass-through.
    ex_valid = 1'b1; ex_wregen = 1'b1; ex_wreg1 = 5'd5; ex_aluout = 64'h1234;
    check("alu.stall_t", {63'd0, mem_stall}, 64'd0);
    step();
    idle_in();
    check_out("alu", 1'b1, 5'd5, 64'h1234, 1'b0);
    check("alu.stall", {63'd0, mem_stall}, 64'd0);
    step();
    check_out("bubble", 1'b0, 5'd0, 64'd0, 1'b0);

    // Store then load to 0x40.
    mem_op("st40", 1'b0, 1'b1, 1'b0, 5'd0, 64'h40, 64'hDEADBEEF_CAFEF00D);
    check_out("st40", 1'b0, 5'd0, 64'd0, 1'b0);
    mem_op("ld40", 1'b1, 1'b0, 1'b1, 5'd9, 64'h40, 64'd0);
    check_out("ld40", 1'b1, 5'd9, 64'hDEADBEEF_CAFEF00D, 1'b0);

    // Wrap-around: index 0 is seeded first so both builds have a defined expectation.
    mem_op("st0", 1'b0, 1'b1, 1'b0, 5'd0, 64'h0, 64'h55);
    mem_op("st800", 1'b0, 1'b1, 1'b0, 5'd0, 64'h800, 64'h11);
`ifdef MEM_STAGE_RANGE_CHECK_EN
    check_out("st800", 1'b0, 5'd0, 64'd0, 1'b1);
    step();
    check("st800.err_once", {63'd0, mem_err}, 64'd0);
    mem_op("ld0", 1'b1, 1'b0, 1'b1, 5'd1, 64'h0, 64'd0);
    check_out("ld0", 1'b1, 5'd1, 64'h55, 1'b0);
    mem_op("ld45", 1'b1, 1'b0, 1'b1, 5'd2, 64'h45, 64'd0);
    check_out("ld45", 1'b0, 5'd0, 64'd0, 1'b1);
`else
    check_out("st800", 1'b0, 5'd0, 64'd0, 1'b0);
    mem_op("ld0", 1'b1, 1'b0, 1'b1, 5'd1, 64'h0, 64'd0);
    check_out("ld0", 1'b1, 5'd1, 64'h11, 1'b0);
    mem_op("ld45", 1'b1, 1'b0, 1'b1, 5'd2, 64'h45, 64'd0);
    check_out("ld45", 1'b1, 5'd2, 64'hDEADBEEF_CAFEF00D, 1'b0);
`endif

    // MemRead and MemWrite both set behaves as a store with no writeback.
    mem_op("rdwr", 1'b1, 1'b1, 1'b1, 5'd7, 64'h18, 64'hA5A5);
    check_out("rdwr", 1'b0, 5'd0, 64'd0, 1'b0);
    mem_op("ld18", 1'b1, 1'b0, 1'b1, 5'd7, 64'h18, 64'd0);
    check_out("ld18", 1'b1, 5'd7, 64'hA5A5, 1'b0);

    // Reset during BUSY aborts a pending store.
    mem_op("st8old", 1'b0, 1'b1, 1'b0, 5'd0, 64'h8, 64'h1111);
    ex_valid = 1'b1; ex_memwrite = 1'b1; ex_aluout = 64'h8; ex_storedata = 64'h2222;
    step();
    idle_in();
    check("abort.stall_t1", {63'd0, mem_stall}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_out("abort", 1'b0, 5'd0, 64'd0, 1'b0);
    check("abort.stall", {63'd0, mem_stall}, 64'd0);
    step();
    check("abort.idle", {63'd0, mem_stall}, 64'd0);
    mem_op("ld8", 1'b1, 1'b0, 1'b1, 5'd12, 64'h8, 64'd0);
    check_out("ld8", 1'b1, 5'd12, 64'h1111, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
